// File: rtl/dfdd_pkg.sv
// Shared types and widths for the DFDD frame sequencer.
package dfdd_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COORD_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/dfdd_frame_sequencer_credit_counter.sv
// Credit counter bounding in-flight results; saturates at CREDITS and flags over-return.
module dfdd_credit_counter #(
  parameter int unsigned CREDITS = 16,
  localparam int unsigned CW     = $clog2(CREDITS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          take_i,
  input  logic          return_i,
  output logic [CW-1:0] credits_o,
  output logic [CW-1:0] credits_next_o,
  output logic          overflow_o
);

  logic [CW-1:0] credits_q, credits_d;
  logic          full, ret_ok;

  assign full       = (credits_q == CW'(CREDITS));
  assign ret_ok     = return_i & ~full;
  assign overflow_o = return_i & full;

  // A return at full credits has no matching result, so it is dropped.
  always_comb begin
    credits_d = credits_q;
    case ({take_i, ret_ok})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      credits_q <= CW'(CREDITS);
    end else begin
      credits_q <= credits_d;
    end
  end

  assign credits_o      = credits_q;
  assign credits_next_o = credits_d;

endmodule

// File: rtl/dfdd_frame_sequencer.sv
// Joins rho-plus/rho-minus pixel streams, stamps raster coordinates and issues them
// to the DFDD datapath under credit flow control; drains results before frame done.
module dfdd_frame_sequencer
  import dfdd_pkg::*;
#(
  parameter int unsigned CREDITS = 16,
  localparam int unsigned CW     = $clog2(CREDITS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [COORD_W-1:0] width_i,
  input  logic [COORD_W-1:0] height_i,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               err_o,
  input  logic [PIX_W-1:0]   plus_data_i,
  input  logic               plus_valid_i,
  output logic               plus_ready_o,
  input  logic [PIX_W-1:0]   minus_data_i,
  input  logic               minus_valid_i,
  output logic               minus_ready_o,
  output logic [PIX_W-1:0]   dp_rho_plus_o,
  output logic [PIX_W-1:0]   dp_rho_minus_o,
  output logic [COORD_W-1:0] dp_col_o,
  output logic [COORD_W-1:0] dp_row_o,
  output logic               dp_valid_o,
  input  logic               credit_return_i,
  output logic [CW-1:0]      credits_o
);

  state_e             state_q;
  logic [COORD_W-1:0] width_q, height_q, col_q, row_q, dp_col_q, dp_row_q;
  logic [PIX_W-1:0]   dp_plus_q, dp_minus_q;
  logic               dp_valid_q, err_q;
  logic [CW-1:0]      credits, credits_next;
  logic               overflow, run, has_credit, fire, last_col, last_row, dims_ok;

  assign run        = (state_q == StRun);
  assign has_credit = (credits != '0);
  assign fire       = run & plus_valid_i & minus_valid_i & has_credit;
  assign last_col   = (col_q == width_q - COORD_W'(1));
  assign last_row   = (row_q == height_q - COORD_W'(1));
  assign dims_ok    = (width_i != '0) && (height_i != '0);

  // Each side is only accepted together with its partner.
  assign plus_ready_o  = run & has_credit & minus_valid_i;
  assign minus_ready_o = run & has_credit & plus_valid_i;

  dfdd_credit_counter #(
    .CREDITS(CREDITS)
  ) u_credit_counter (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .take_i         (fire),
    .return_i       (credit_return_i),
    .credits_o      (credits),
    .credits_next_o (credits_next),
    .overflow_o     (overflow)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      dp_plus_q  <= '0;
      dp_minus_q <= '0;
      dp_col_q   <= '0;
      dp_row_q   <= '0;
      dp_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dp_valid_q <= fire;
      if (fire) begin
        dp_plus_q  <= plus_data_i;
        dp_minus_q <= minus_data_i;
        dp_col_q   <= col_q;
        dp_row_q   <= row_q;
      end
      if (overflow) err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (dims_ok) begin
              width_q  <= width_i;
              height_q <= height_i;
              col_q    <= '0;
              row_q    <= '0;
              state_q  <= StRun;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (fire) begin
            if (last_col) begin
              if (last_row) begin
                state_q <= StDrain;
              end else begin
                col_q <= '0;
                row_q <= row_q + COORD_W'(1);
              end
            end else begin
              col_q <= col_q + COORD_W'(1);
            end
          end
        end
        // Look at next-state credits so the final return completes the drain at once.
        StDrain: if (credits_next == CW'(CREDITS)) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign frame_done_o   = (state_q == StDone);
  assign err_o          = err_q;
  assign dp_rho_plus_o  = dp_plus_q;
  assign dp_rho_minus_o = dp_minus_q;
  assign dp_col_o       = dp_col_q;
  assign dp_row_o       = dp_row_q;
  assign dp_valid_o     = dp_valid_q;
  assign credits_o      = credits;

endmodule

// File: tb/tb_dfdd_frame_sequencer.sv
// Directed bench for dfdd_frame_sequencer: scoreboard of expected issues, checked on dp_valid_o.
module tb_dfdd_frame_sequencer;

  localparam int unsigned CREDITS = 4;
  localparam int unsigned CW      = $clog2(CREDITS + 1);

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i;
  logic [15:0]   width_i, height_i;
  logic          busy_o, frame_done_o, err_o;
  logic [7:0]    plus_data_i, minus_data_i;
  logic          plus_valid_i, minus_valid_i, plus_ready_o, minus_ready_o;
  logic [7:0]    dp_rho_plus_o, dp_rho_minus_o;
  logic [15:0]   dp_col_o, dp_row_o;
  logic          dp_valid_o;
  logic          credit_return_i;
  logic [CW-1:0] credits_o;

  dfdd_frame_sequencer #(
    .CREDITS(CREDITS)
  ) u_dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .start_i         (start_i),
    .width_i         (width_i),
    .height_i        (height_i),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
    .err_o           (err_o),
    .plus_data_i     (plus_data_i),
    .plus_valid_i    (plus_valid_i),
    .plus_ready_o    (plus_ready_o),
    .minus_data_i    (minus_data_i),
    .minus_valid_i   (minus_valid_i),
    .minus_ready_o   (minus_ready_o),
    .dp_rho_plus_o   (dp_rho_plus_o),
    .dp_rho_minus_o  (dp_rho_minus_o),
    .dp_col_o        (dp_col_o),
    .dp_row_o        (dp_row_o),
    .dp_valid_o      (dp_valid_o),
    .credit_return_i (credit_return_i),
    .credits_o       (credits_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]  p;
    logic [7:0]  m;
    logic [15:0] c;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  int   n_issued = 0, n_done = 0, n_pushed = 0, n_returned = 0;
  int   pix = 0, ecol = 0, erow = 0, fw = 1, fh = 1, remaining = 0;
  int   frame_i0 = 0, frame_d0 = 0;

  function automatic logic [7:0] pd(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] md(input int i);
    return 8'(i * 13 + 100);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream observer: every issue must match the next expected pair.
  always @(posedge clk_i) begin
    #1;
    if (rst_n_i) begin
      if (frame_done_o) n_done++;
      if (dp_valid_o) begin
        n_issued++;
        if (sb.size() == 0) begin
          check("unexpected_issue", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("dp_rho_plus", 32'(dp_rho_plus_o), 32'(mon_e.p));
          check("dp_rho_minus", 32'(dp_rho_minus_o), 32'(mon_e.m));
          check("dp_col", 32'(dp_col_o), 32'(mon_e.c));
          check("dp_row", 32'(dp_row_o), 32'(mon_e.r));
        end
      end
    end
  end

  task automatic tick(input logic pv, input logic mv, input logic ret);
    @(negedge clk_i);
    plus_valid_i    = pv;
    minus_valid_i   = mv;
    credit_return_i = ret;
    plus_data_i     = pd(pix);
    minus_data_i    = md(pix);
    if (ret) n_returned++;
    #1;
    if (pv && mv && plus_ready_o && minus_ready_o) begin
      sb.push_back('{p: pd(pix), m: md(pix), c: 16'(ecol), r: 16'(erow)});
      pix++;
      n_pushed++;
      remaining--;
      if (ecol == fw - 1) begin
        ecol = 0;
        erow++;
      end else begin
        ecol++;
      end
    end
  endtask

  task automatic start_frame(input int w, input int h);
    @(negedge clk_i);
    start_i         = 1'b1;
    width_i         = 16'(w);
    height_i        = 16'(h);
    plus_valid_i    = 1'b0;
    minus_valid_i   = 1'b0;
    credit_return_i = 1'b0;
    fw = w; fh = h; ecol = 0; erow = 0; remaining = w * h;
    frame_i0 = n_issued;
    frame_d0 = n_done;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  // Feed remaining pixels, return outstanding results, and verify the frame closes.
  task automatic finish_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (n_done != frame_d0) begin
        seen = 1'b1;
        break;
      end
      tick(remaining > 0, remaining > 0, n_pushed > n_returned);
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("frame_done_pulses", 32'(n_done - frame_d0), 32'd1);
    check("frame_issues", 32'(n_issued - frame_i0), 32'(fw * fh));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("busy_after_frame", 32'(busy_o), 32'd0);
    check("credits_after_frame", 32'(credits_o), 32'(CREDITS));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    sb.delete();
    n_returned = n_pushed;
    remaining  = 0;
    rst_n_i    = 1'b1;
  endtask

  initial begin
    int   p0, rb;
    logic mv;
    rst_n_i = 1'b0;
    start_i = 1'b0;
    width_i = '0;
    height_i = '0;
    plus_data_i = '0;
    minus_data_i = '0;
    plus_valid_i = 1'b1;
    minus_valid_i = 1'b1;
    credit_return_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_credits", 32'(credits_o), 32'(CREDITS));
    check("rst_plus_ready", 32'(plus_ready_o), 32'd0);
    check("rst_minus_ready", 32'(minus_ready_o), 32'd0);
    check("rst_dp_valid", 32'(dp_valid_o), 32'd0);
    check("rst_dp_col", 32'(dp_col_o), 32'd0);
    rst_n_i = 1'b1;
    plus_valid_i = 1'b0;
    minus_valid_i = 1'b0;

    // 4x2 frame, both streams valid, results returned promptly.
    start_frame(4, 2);
    finish_frame();

    // plus held valid, minus toggling: readies follow the partner's valid.
    start_frame(2, 2);
    for (int i = 0; i < 40 && remaining > 0; i++) begin
      rb = remaining;
      mv = (i % 2) == 0;
      tick(1'b1, mv, n_pushed > n_returned);
      if (rb > 0) begin
        check("toggle_plus_ready", 32'(plus_ready_o), 32'(mv));
        check("toggle_minus_ready", 32'(minus_ready_o), 32'd1);
      end
    end
    finish_frame();

    // Credit stall: no returns, only CREDITS issues, then one return buys one issue.
    start_frame(8, 1);
    repeat (6) tick(1'b1, 1'b1, 1'b0);
    check("stall_issues", 32'(n_issued - frame_i0), 32'(CREDITS));
    check("stall_credits", 32'(credits_o), 32'd0);
    check("stall_plus_ready", 32'(plus_ready_o), 32'd0);
    check("stall_minus_ready", 32'(minus_ready_o), 32'd0);
    tick(1'b1, 1'b1, 1'b1);
    check("stall_ready_during_return", 32'(plus_ready_o), 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    check("resume_ready", 32'(plus_ready_o), 32'd1);
    tick(1'b1, 1'b1, 1'b0);
    check("restall_ready", 32'(minus_ready_o), 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    check("one_more_issue", 32'(n_issued - frame_i0), 32'(CREDITS + 1));
    finish_frame();

    // Drain with three results outstanding after the last pixel.
    start_frame(3, 1);
    for (int i = 0; i < 20 && remaining > 0; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("drain_busy_1", 32'(busy_o), 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    check("drain_done_2", 32'(frame_done_o), 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    check("drain_done_3", 32'(frame_done_o), 32'd0);
    check("drain_busy_3", 32'(busy_o), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("drain_done_after", 32'(frame_done_o), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("drain_done_pulse_end", 32'(frame_done_o), 32'd0);
    check("drain_idle", 32'(busy_o), 32'd0);
    check("drain_issues", 32'(n_issued - frame_i0), 32'd3);

    // Over-return at full credits saturates and raises the sticky error.
    check("err_clean", 32'(err_o), 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("overflow_credits", 32'(credits_o), 32'(CREDITS));
    check("overflow_err", 32'(err_o), 32'd1);
    do_reset();
    #1;
    check("err_cleared_by_reset", 32'(err_o), 32'd0);

    // Zero width start is refused.
    @(negedge clk_i);
    start_i = 1'b1; width_i = 16'd0; height_i = 16'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("zero_dim_busy", 32'(busy_o), 32'd0);
    check("zero_dim_err", 32'(err_o), 32'd1);
    do_reset();

    // Reset mid-row, then a clean 1x1 frame.
    start_frame(8, 2);
    p0 = n_pushed;
    for (int i = 0; i < 20 && (n_pushed - p0) < 3; i++) tick(1'b1, 1'b1, n_pushed > n_returned);
    tick(1'b0, 1'b0, n_pushed > n_returned);
    check("midrow_col", 32'(dp_col_o), 32'd2);
    @(negedge clk_i);
    plus_valid_i = 1'b1; minus_valid_i = 1'b1; credit_return_i = 1'b0;
    #1;
    check("midrow_ready_pre", 32'(plus_ready_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_plus_ready", 32'(plus_ready_o), 32'd0);
    check("midrst_minus_ready", 32'(minus_ready_o), 32'd0);
    check("midrst_credits", 32'(credits_o), 32'(CREDITS));
    check("midrst_dp_col", 32'(dp_col_o), 32'd0);
    check("midrst_dp_plus", 32'(dp_rho_plus_o), 32'd0);
    check("midrst_dp_valid", 32'(dp_valid_o), 32'd0);
    sb.delete();
    n_returned = n_pushed;
    remaining = 0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    plus_valid_i = 1'b0; minus_valid_i = 1'b0;
    start_frame(1, 1);
    finish_frame();
    check("tiny_col", 32'(dp_col_o), 32'd0);
    check("tiny_row", 32'(dp_row_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dfdd_frame_sequencer.md
# dfdd_frame_sequencer

Raster-frame controller in front of the DFDD depth/confidence datapath. It joins two 8-bit pixel streams (rho-plus and rho-minus images) into one issue stream and stamps each pair with col/row raster coordinates. A credit counter bounds the number of results in flight so the downstream result buffer never overflows. Once the last pixel of the frame is issued, it drains all outstanding results and then signals frame completion.

## Interface
- CREDITS, 16: downstream result-buffer slots; max in-flight results (>=1).
- CW, $clog2(CREDITS+1): local; credit counter width.
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  frame start request; sampled in IDLE only.
- width_i  in  16  frame width in pixels; latched on accepted start.
- height_i  in  16  frame height in rows; latched on accepted start.
- busy_o  out  1  state != IDLE.
- frame_done_o  out  1  one-cycle pulse when the frame is fully drained.
- err_o  out  1  sticky error flag (bad start dims, credit overflow).
- plus_data_i  in  8  rho-plus pixel.
- plus_valid_i  in  1  rho-plus pixel valid.
- plus_ready_o  out  1  rho-plus pixel accepted when high with valid.
- minus_data_i  in  8  rho-minus pixel.
- minus_valid_i  in  1  rho-minus pixel valid.
- minus_ready_o  out  1  rho-minus pixel accepted when high with valid.
- dp_rho_plus_o  out  8  to datapath i_rho_plus_uint8.
- dp_rho_minus_o  out  8  to datapath i_rho_minus_uint8.
- dp_col_o  out  16  pixel column.
- dp_row_o  out  16  pixel row.
- dp_valid_o  out  1  issue strobe to datapath.
- credit_return_i  in  1  one pulse per result consumed downstream.
- credits_o  out  CW  currently available credits.

## Operation
- Reset values: state IDLE, credits = CREDITS, col = row = 0, all dp_* = 0, busy_o = frame_done_o = err_o = 0, both readies = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i with width_i != 0 and height_i != 0. Dims are latched; col and row are cleared.
  - start_i with a zero dimension: stay in IDLE, set err_o.
  - start_i outside IDLE: ignored.
  - RUN -> DRAIN on a fire at col == W-1 and row == H-1.
  - DRAIN -> DONE when credits == CREDITS, i.e. all results have been returned. This transition can happen in the same cycle as the last return.
  - DONE -> IDLE unconditionally after one cycle.
- Join and ready rules:
  - plus_ready_o = RUN & (credits != 0) & minus_valid_i.
  - minus_ready_o = RUN & (credits != 0) & plus_valid_i.
  - fire = RUN & plus_valid_i & minus_valid_i & (credits != 0). A stream is never consumed alone.
- Raster counter, on each fire:
  - col increments.
  - At col == W-1, col wraps to 0 and row increments.
  - No wrap occurs beyond the last pixel.
- Credit counter:
  - credits_next = credits - fire + credit_return_i.
  - Simultaneous fire and return: credits unchanged.
  - A return while credits == CREDITS: credits hold (saturate) and err_o is set.
  - Returns are accepted in every state.
- err_o clears only on reset.
- Reset mid-frame: everything returns to the reset values immediately, and in-flight results are forgotten. The downstream datapath must be reset together with this block.

## Timing
- Issue latency: a fire in cycle N presents dp_valid_o and the registered dp_* in cycle N+1. dp_valid_o is high for exactly one cycle per fire.
- Throughput: 1 pixel/cycle when both streams are valid and credits > 0.
- Start: start_i accepted at edge N puts RUN in effect from N+1; the earliest dp_valid_o is N+2.
- busy_o is decoded from the state register.
- frame_done_o is high exactly in the DONE cycle.
- Credit stall: with credits == 0, both readies are low in the same cycle (combinational from the credit register). Issue resumes the cycle after a return.

## Structure
- Shared package dfdd_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - PIX_W = 8;
  - COORD_W = 16.
- Sub-module dfdd_credit_counter (parameter CREDITS): contains the credit counter with saturation and the overflow flag.
- The FSM, join logic and raster counter stay in the top module.

## Test plan
- 4x2 frame, CREDITS=16, both streams always valid, immediate returns: 8 dp_valid_o pulses, coordinates (0,0)..(3,0),(0,1)..(3,1), frame_done_o once, then busy_o=0.
- CREDITS=2, no returns: exactly 2 issues, then both readies low. One return produces exactly one more issue the next cycle.
- plus_valid_i held high, minus_valid_i toggled every other cycle: no fire without both valid, plus_ready_o follows minus_valid_i, pixels are paired in order.
- Last pixel issued with 3 results outstanding: stays in DRAIN until the third return, then frame_done_o in the cycle after it.
- start_i with width_i=0: stays in IDLE and err_o=1. An extra credit_return_i at full credits: credits_o=CREDITS and err_o=1.
- rst_n_i asserted mid-row at col=2: outputs go to reset values immediately. A new 1x1 frame then completes normally with dp_col_o = dp_row_o = 0.
